// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port; ownership held from issue to completion.
// Optional round-robin contention policy via `MEM_ARB_RR_EN (default: fixed m0 priority).
module mem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MEM_ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0]     m0_data_in,
  input  logic                      m0_r_en,
  input  logic                      m0_w_en,
  output logic                      m0_rdy,
  output logic                      m0_cplt,
  input  logic [MEM_ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0]     m1_data_in,
  input  logic                      m1_r_en,
  input  logic                      m1_w_en,
  output logic                      m1_rdy,
  output logic                      m1_cplt,
  output logic [DATA_WIDTH-1:0]     m_data_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_data_in,
  output logic                      mem_r_en,
  output logic                      mem_w_en,
  input  logic [DATA_WIDTH-1:0]     mem_data_out,
  input  logic                      mem_rdy,
  input  logic                      mem_cplt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
`ifdef MEM_ARB_RR_EN
  logic   last_q, last_d;
`endif

  logic pend0, pend1, any_pend;
  logic arb_win;
  logic gnt_pend, gnt_r, gnt_w;
  logic in_issue, in_wait;

  assign pend0    = m0_r_en | m0_w_en;
  assign pend1    = m1_r_en | m1_w_en;
  assign any_pend = pend0 | pend1;

  assign gnt_r    = gnt_q ? m1_r_en : m0_r_en;
  assign gnt_w    = gnt_q ? m1_w_en : m0_w_en;
  assign gnt_pend = gnt_r | gnt_w;

  assign in_issue = (state_q == ISSUE);
  assign in_wait  = (state_q == WAIT);

  // Winner when both pend: the master not served last, or always m0.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    arb_win = (pend0 & pend1) ? ~last_q : pend1;
`else
    arb_win = pend1 & ~pend0;
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_pend) begin
          gnt_d   = arb_win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!gnt_pend) begin
          state_d = IDLE;
        end else if (mem_rdy) begin
          state_d = WAIT;
`ifdef MEM_ARB_RR_EN
          last_d  = gnt_q;
`endif
        end
      end
      WAIT: begin
        if (mem_cplt) begin
          if (any_pend) begin
            gnt_d   = arb_win;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Write takes precedence if a master raises both enables.
  assign mem_w_en = in_issue & gnt_w;
  assign mem_r_en = in_issue & gnt_r & ~gnt_w;

  assign mem_addr    = in_issue ? (gnt_q ? m1_addr : m0_addr) : '0;
  assign mem_data_in = in_issue ? (gnt_q ? m1_data_in : m0_data_in) : '0;

  assign m0_rdy  = in_issue & ~gnt_q & pend0 & mem_rdy;
  assign m1_rdy  = in_issue &  gnt_q & pend1 & mem_rdy;
  assign m0_cplt = in_wait  & ~gnt_q & mem_cplt;
  assign m1_cplt = in_wait  &  gnt_q & mem_cplt;

  assign m_data_out = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Contention expectations follow `MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [19:0] m0_addr, m1_addr, mem_addr;
  logic [15:0] m0_data_in, m1_data_in;
  logic        m0_r_en, m0_w_en, m1_r_en, m1_w_en;
  logic        m0_rdy, m0_cplt, m1_rdy, m1_cplt;
  logic [15:0] m_data_out, mem_data_in, mem_data_out;
  logic        mem_r_en, mem_w_en, mem_rdy, mem_cplt;

  int n_checks;
  int n_fail;

  mem_arbiter #(
    .MEM_ADDR_WIDTH(20),
    .DATA_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m0_addr(m0_addr),
    .m0_data_in(m0_data_in),
    .m0_r_en(m0_r_en),
    .m0_w_en(m0_w_en),
    .m0_rdy(m0_rdy),
    .m0_cplt(m0_cplt),
    .m1_addr(m1_addr),
    .m1_data_in(m1_data_in),
    .m1_r_en(m1_r_en),
    .m1_w_en(m1_w_en),
    .m1_rdy(m1_rdy),
    .m1_cplt(m1_cplt),
    .m_data_out(m_data_out),
    .mem_addr(mem_addr),
    .mem_data_in(mem_data_in),
    .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en),
    .mem_data_out(mem_data_out),
    .mem_rdy(mem_rdy),
    .mem_cplt(mem_cplt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m0_addr = '0; m0_data_in = '0; m0_r_en = 0; m0_w_en = 0;
    m1_addr = '0; m1_data_in = '0; m1_r_en = 0; m1_w_en = 0;
    mem_data_out = '0; mem_rdy = 0; mem_cplt = 0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".r"}, 32'(mem_r_en), 0);
    check({tag, ".w"}, 32'(mem_w_en), 0);
    check({tag, ".a"}, 32'(mem_addr), 0);
    check({tag, ".d"}, 32'(mem_data_in), 0);
    check({tag, ".rdy"}, 32'({m0_rdy, m1_rdy}), 0);
    check({tag, ".cplt"}, 32'({m0_cplt, m1_cplt}), 0);
  endtask

  task automatic do_reset();
    rst = 0;
    clr();
    repeat (2) cyc();
    rst = 1;
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 0;
    clr();
    #2;
    chk_zero("rst");
    repeat (2) cyc();
    rst = 1;
    cyc();

    // single read from m0
    m0_r_en = 1; m0_addr = 20'h00123; mem_rdy = 1;
    #1;
    check("rd.idle_ren", 32'(mem_r_en), 0);
    cyc();
    check("rd.ren", 32'(mem_r_en), 1);
    check("rd.addr", 32'(mem_addr), 32'h123);
    check("rd.rdy", 32'({m0_rdy, m1_rdy}), 32'b10);
    cyc();
    m0_r_en = 0;
    #1;
    check("rd.wait_ren", 32'(mem_r_en), 0);
    check("rd.wait_rdy", 32'(m0_rdy), 0);
    check("rd.wait_addr", 32'(mem_addr), 0);
    cyc();
    check("rd.cplt_early", 32'({m0_cplt, m1_cplt}), 0);
    cyc();
    mem_cplt = 1; mem_data_out = 16'hBEEF;
    #1;
    check("rd.cplt", 32'({m0_cplt, m1_cplt}), 32'b10);
    check("rd.data", 32'(m_data_out), 32'hBEEF);
    cyc();
    mem_cplt = 0;
    #1;
    check("rd.after_cplt", 32'({m0_cplt, m1_cplt}), 0);
    check("rd.idle", 32'(mem_r_en), 0);

    // contention from fresh reset
    do_reset();
    m0_r_en = 1; m0_addr = 20'h00010;
    m1_w_en = 1; m1_addr = 20'h00020; m1_data_in = 16'hA5A5;
    mem_rdy = 1;
    cyc();
    #1;
    check("ct.first_addr", 32'(mem_addr), 32'h10);
    check("ct.first_en", 32'({mem_r_en, mem_w_en}), 32'b10);
    check("ct.first_rdy", 32'({m0_rdy, m1_rdy}), 32'b10);
    cyc();
    mem_cplt = 1;
    #1;
    check("ct.m0_cplt", 32'({m0_cplt, m1_cplt}), 32'b10);
    cyc();
    mem_cplt = 0;
    #1;
`ifdef MEM_ARB_RR_EN
    check("ct.second_addr", 32'(mem_addr), 32'h20);
    check("ct.second_data", 32'(mem_data_in), 32'hA5A5);
    check("ct.second_en", 32'({mem_r_en, mem_w_en}), 32'b01);
    check("ct.second_rdy", 32'({m0_rdy, m1_rdy}), 32'b01);
`else
    check("ct.second_addr", 32'(mem_addr), 32'h10);
    check("ct.second_en", 32'({mem_r_en, mem_w_en}), 32'b10);
    check("ct.second_rdy", 32'({m0_rdy, m1_rdy}), 32'b10);
`endif
    cyc();
    m0_r_en = 0; m1_w_en = 0; mem_cplt = 1;
    #1;
`ifdef MEM_ARB_RR_EN
    check("ct.second_cplt", 32'({m0_cplt, m1_cplt}), 32'b01);
`else
    check("ct.second_cplt", 32'({m0_cplt, m1_cplt}), 32'b10);
`endif
    cyc();
    clr();
    #1;
    chk_zero("ct.end");

    // backpressure on m1 write
    cyc();
    m1_w_en = 1; m1_addr = 20'h00ABC; m1_data_in = 16'h1234;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.wen", 32'(mem_w_en), 1);
      check("bp.addr", 32'(mem_addr), 32'hABC);
      check("bp.data", 32'(mem_data_in), 32'h1234);
      check("bp.rdy", 32'({m0_rdy, m1_rdy}), 0);
      cyc();
    end
    mem_rdy = 1;
    #1;
    check("bp.rdy_pulse", 32'({m0_rdy, m1_rdy}), 32'b01);
    cyc();
    m1_w_en = 0;
    #1;
    check("bp.rdy_once", 32'({m0_rdy, m1_rdy}), 0);
    check("bp.wait_wen", 32'(mem_w_en), 0);
    mem_cplt = 1;
    #1;
    check("bp.cplt", 32'({m0_cplt, m1_cplt}), 32'b01);
    cyc();
    clr();

    // withdrawal of m1 read while stalled
    m1_r_en = 1; m1_addr = 20'h00055;
    cyc();
    #1;
    check("wd.ren", 32'(mem_r_en), 1);
    m1_r_en = 0;
    cyc();
    mem_cplt = 1;
    #1;
    check("wd.idle_ren", 32'(mem_r_en), 0);
    check("wd.no_cplt", 32'({m0_cplt, m1_cplt}), 0);
    cyc();
    mem_cplt = 0;
    m1_r_en = 1; m1_addr = 20'h00066; mem_rdy = 1;
    #1;
    check("wd.idle2", 32'(mem_r_en), 0);
    cyc();
    #1;
    check("wd.re_addr", 32'(mem_addr), 32'h66);
    check("wd.re_rdy", 32'({m0_rdy, m1_rdy}), 32'b01);
    cyc();
    m1_r_en = 0; mem_cplt = 1;
    #1;
    check("wd.re_cplt", 32'({m0_cplt, m1_cplt}), 32'b01);
    cyc();
    clr();

    // async reset during WAIT
    m0_r_en = 1; m0_addr = 20'h00077; mem_rdy = 1;
    cyc();
    cyc();
    m0_r_en = 0;
    #2;
    rst = 0;
    #1;
    chk_zero("ar.async");
    cyc();
    rst = 1;
    cyc();
    mem_cplt = 1;
    #1;
    check("ar.late_cplt", 32'({m0_cplt, m1_cplt}), 0);
    cyc();
    clr();

    // m0 raises both enables: write wins
    m0_r_en = 1; m0_w_en = 1; m0_addr = 20'h00099;
    m0_data_in = 16'h5A5A; mem_rdy = 1;
    cyc();
    #1;
    check("rw.en", 32'({mem_r_en, mem_w_en}), 32'b01);
    check("rw.data", 32'(mem_data_in), 32'h5A5A);
    cyc();
    m0_r_en = 0; m0_w_en = 0; mem_cplt = 1;
    #1;
    check("rw.cplt", 32'({m0_cplt, m1_cplt}), 32'b10);
    cyc();
    clr();
    #1;
    chk_zero("end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single CPU memory port between the core (master 0) and a second requester (master 1), e.g. a program loader or DMA engine.
- Sits between the masters and the memory controller, using the same rdy/cplt handshake on both sides.
- Grants one transaction at a time and holds ownership from issue until completion.
- Routes completion back to the owning master only.

Parameters:
- MEM_ADDR_WIDTH, 20, memory address width in bits.
- DATA_WIDTH, 16, data word width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_addr  in  MEM_ADDR_WIDTH  master 0 address.
- m0_data_in  in  DATA_WIDTH  master 0 write data.
- m0_r_en  in  1  master 0 read request.
- m0_w_en  in  1  master 0 write request.
- m0_rdy  out  1  master 0 request accepted this cycle.
- m0_cplt  out  1  master 0 transaction complete (1-cycle pulse).
- m1_addr, m1_data_in, m1_r_en, m1_w_en, m1_rdy, m1_cplt: master 1 equivalents, same widths and meaning.
- m_data_out  out  DATA_WIDTH  read data, shared by both masters; equals mem_data_out.
- mem_addr  out  MEM_ADDR_WIDTH  address to memory.
- mem_data_in  out  DATA_WIDTH  write data to memory.
- mem_r_en  out  1  read enable to memory.
- mem_w_en  out  1  write enable to memory.
- mem_data_out  in  DATA_WIDTH  read data from memory.
- mem_rdy  in  1  memory can accept a request.
- mem_cplt  in  1  memory completion pulse.

Behaviour:
- Handshake rules:
  - A master request is pending while r_en|w_en is high.
  - The master holds addr, data and enables stable until its rdy pulse.
  - A request is accepted in a cycle where the memory enable and mem_rdy are both high.
  - mem_cplt is never earlier than the cycle after acceptance.
- States: IDLE, ISSUE, WAIT. Registers: state, gnt (1 bit), last (1 bit).
- Reset (rst low, async): state=IDLE, gnt=0, last=1. All outputs 0: mem_r_en, mem_w_en, mem_addr, mem_data_in, m0/m1_rdy, m0/m1_cplt.
- Arbitration function (used in IDLE and on completion):
  - Only one master pending: that master wins.
  - Both pending: winner per the arbitration policy (see Optional Feature).
  - The winner is registered into gnt.
- IDLE:
  - Memory enables are 0.
  - Any request pending: arbitrate, go to ISSUE next cycle.
- ISSUE:
  - mem_addr, mem_data_in, mem_r_en, mem_w_en are combinationally muxed from master gnt.
  - If gnt master has w_en=1, mem_r_en is forced 0 (write wins if both enables are set).
  - m<gnt>_rdy = mem_rdy & (gnt master pending). The other master's rdy is 0.
  - On acceptance: WAIT, and last <= gnt.
  - If the granted master drops its request before acceptance (withdrawal): IDLE, last unchanged.
  - mem_cplt in ISSUE is ignored.
- WAIT:
  - Memory enables are 0; mem_addr and mem_data_in are driven 0.
  - m<gnt>_cplt = mem_cplt, combinational.
  - On mem_cplt, arbitrate in the same cycle, using last = gnt as updated on acceptance:
    - Any request pending: go directly to ISSUE.
    - Otherwise: IDLE.
- Outside ISSUE: mem_addr and mem_data_in are 0; rdy outputs are 0. cplt outputs are 0 outside WAIT.
- Latency: request in IDLE at cycle N gives ISSUE at N+1. With mem_rdy=1, accept at N+1 and WAIT at N+2. Back-to-back: ISSUE in the cycle after cplt.
- A master whose request is not granted sees rdy=0 and keeps waiting. No request is ever dropped.
- Reset mid-transaction aborts the transaction. No cplt is delivered afterwards; a late mem_cplt arriving in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. When both masters are pending, the winner is the master != last. This guarantees alternation under contention; first contention after reset grants m0.
- Undefined: fixed priority. m0 always wins contention and the last register is not implemented; m1 can starve.

Test Plan:
- Single read: m0_r_en=1, m0_addr=0x00123, mem_rdy=1, mem_cplt 3 cycles after acceptance with mem_data_out=0xBEEF -> mem_r_en=1 and mem_addr=0x00123 one cycle after request; m0_rdy pulses once; m0_cplt pulses once with m_data_out=0xBEEF; m1_cplt stays 0.
- Contention: m0 reads 0x00010 and m1 writes 0xA5A5 to 0x00020, both asserted same cycle after reset -> RR build: m0 served first, then m1 ISSUE in the cycle after m0_cplt; fixed build: m0 keeps winning while held, m1 waits.
- Backpressure: mem_rdy=0 for 5 cycles during ISSUE for m1 write -> mem_w_en held 1 with stable addr/data, m1_rdy=0 until mem_rdy=1, then a single rdy pulse.
- Withdrawal: m1_r_en dropped in ISSUE while mem_rdy=0 -> state IDLE next cycle, no cplt, and a subsequent m1 request is served normally.
- Async reset: assert rst low in WAIT between edges -> all outputs 0 immediately; a mem_cplt pulse after release produces no m0/m1_cplt.
- Simultaneous r_en=w_en=1 on m0 -> mem_w_en=1, mem_r_en=0.
